// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - LEGv8 five-stage pipeline enable/flush sequencer
// Optional performance counters: define PIPE_PERF_COUNTERS_EN.
module pipe_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  typedef enum logic [2:0] {S_INIT, S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] tmo_cnt, tmo_cnt_nx;
  logic [3:0] drn_cnt, drn_cnt_nx;
  logic       mem_err_nx;
  logic       mem_stall;

  assign mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_INIT;
      tmo_cnt <= '0;
      drn_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_cnt_nx;
      drn_cnt <= drn_cnt_nx;
      mem_err <= mem_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    tmo_cnt_nx  = tmo_cnt;
    drn_cnt_nx  = drn_cnt;
    mem_err_nx  = mem_err;
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    halted      = 1'b0;
    case (state)
      S_INIT: begin
        {en_ifid, en_idex, en_exmem, en_memwb}             = 4'b1111;
        {flush_ifid, flush_idex, flush_exmem, flush_memwb} = 4'b1111;
        state_nx = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall) begin
          // Frozen pipeline: branch/load-use stay asserted and are handled after the wait.
          tmo_cnt_nx = tmo_cnt + 8'd1;
          if (tmo_cnt == TMO_LAST) begin
            state_nx   = S_HALTED;
            mem_err_nx = 1'b1;
          end else begin
            state_nx = S_MEM_WAIT;
          end
        end else begin
          tmo_cnt_nx = '0;
          drn_cnt_nx = '0;
          state_nx   = halt_req ? S_DRAIN : S_RUN;
          {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
          if (branch_taken) begin
            {flush_ifid, flush_idex, flush_exmem} = 3'b111;
          end else if (load_use) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (mem_stall) begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
          if (tmo_cnt == TMO_LAST) begin
            state_nx   = S_HALTED;
            mem_err_nx = 1'b1;
          end
        end else begin
          tmo_cnt_nx = '0;
          {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
          flush_ifid = 1'b1;
          if (drn_cnt == DRAIN_LAST) state_nx = S_HALTED;
          else drn_cnt_nx = drn_cnt + 4'd1;
        end
      end
      S_HALTED: halted = 1'b1;
      default:  state_nx = S_INIT;
    endcase
  end

`ifdef PIPE_PERF_COUNTERS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic run_dec, mem_evt, br_evt, lu_evt;
  assign run_dec = (state == S_RUN) || (state == S_MEM_WAIT);
  assign mem_evt = mem_stall && (run_dec || (state == S_DRAIN));
  assign br_evt  = run_dec && !mem_stall && branch_taken;
  assign lu_evt  = run_dec && !mem_stall && !branch_taken && load_use;

  // Saturating counters: they hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (lu_evt  && (stall_cnt   != '1)) stall_cnt   <= stall_cnt   + CNT_ONE;
      if (br_evt  && (flush_cnt   != '1)) flush_cnt   <= flush_cnt   + CNT_ONE;
      if (mem_evt && (memwait_cnt != '1)) memwait_cnt <= memwait_cnt + CNT_ONE;
    end
  end
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - randomized self-checking bench for pipe_sequencer
module tb_pipe_sequencer;
  localparam int CNT_W = 32;
  localparam int TMO   = 15;
  localparam int DRN   = 4;
`ifdef PIPE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,idex,exmem,memwb, halted, mem_err}
  localparam logic [10:0] V_INIT = 11'b01111_1111_00;
  localparam logic [10:0] V_NORM = 11'b11111_0000_00;
  localparam logic [10:0] V_LU   = 11'b00111_0100_00;
  localparam logic [10:0] V_BR   = 11'b11111_1110_00;
  localparam logic [10:0] V_FRZ  = 11'b00000_0000_00;
  localparam logic [10:0] V_DRN  = 11'b01111_1000_00;
  localparam logic [10:0] V_HLT  = 11'b00000_0000_10;
  localparam logic [10:0] V_ERR  = 11'b00000_0000_11;

  logic clk = 1'b0;
  logic reset, load_use, branch_taken, dmem_req, dmem_ready, halt_req;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic halted, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
  logic [10:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb), .halted(halted),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .memwait_cnt(memwait_cnt)
  );

  assign obs = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem, flush_memwb, halted, mem_err};

  // Expected control word for one RUN-state cycle, straight from the priority list.
  function automatic logic [10:0] ref_run(input logic lu, br, req, rdy);
    if (req && !rdy) return V_FRZ;
    if (br)          return V_BR;
    if (lu)          return V_LU;
    return V_NORM;
  endfunction

  task automatic cyc(input logic r, lu, br, req, rdy, hr);
    @(negedge clk);
    reset = r; load_use = lu; branch_taken = br;
    dmem_req = req; dmem_ready = rdy; halt_req = hr;
    #1;
  endtask

  // Leaves the design in INIT-complete state: the next cyc() is the first RUN cycle.
  task automatic do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(i == 2, 0, 0, 0, 1, 0);
      n_tests++;
      if (obs !== V_INIT) begin n_fail++; $display("FAIL reset_init[%0d] obs=%b exp=%b", i, obs, V_INIT); end
    end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== V_NORM) begin n_fail++; $display("FAIL reset_run obs=%b exp=%b", obs, V_NORM); end
    n_tests++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(1, 1, 0, 0, 1, 0);
    n_tests++;
    if (obs !== V_LU) begin n_fail++; $display("FAIL lu_cycle obs=%b exp=%b", obs, V_LU); end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== V_NORM) begin n_fail++; $display("FAIL lu_after obs=%b exp=%b", obs, V_NORM); end
    n_tests++;
    if (stall_cnt !== CNT_W'(PERF ? 1 : 0)) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_mem_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1, 0, 0);
      n_tests++;
      if (obs !== V_FRZ) begin n_fail++; $display("FAIL memwait[%0d] obs=%b exp=%b", i, obs, V_FRZ); end
    end
    cyc(1, 0, 1, 1, 1, 0);
    n_tests++;
    if (obs !== V_BR) begin n_fail++; $display("FAIL mem_then_branch obs=%b exp=%b", obs, V_BR); end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (memwait_cnt !== CNT_W'(PERF ? 3 : 0)) begin n_fail++; $display("FAIL memwait_cnt got=%0d exp=%0d", memwait_cnt, PERF ? 3 : 0); end
    n_tests++;
    if (flush_cnt !== CNT_W'(PERF ? 1 : 0)) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_timeout();
    logic [10:0] expv;
    do_reset();
    // One short of the limit must recover cleanly.
    for (int i = 0; i < TMO - 1; i++) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    n_tests++;
    if (obs !== V_NORM) begin n_fail++; $display("FAIL tmo_minus1 obs=%b exp=%b", obs, V_NORM); end
    for (int i = 0; i < TMO; i++) begin
      cyc(1, 0, 0, 1, 0, 0);
      n_tests++;
      if (obs !== V_FRZ) begin n_fail++; $display("FAIL tmo_wait[%0d] obs=%b exp=%b", i, obs, V_FRZ); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_tests++;
      if (obs !== V_ERR) begin n_fail++; $display("FAIL tmo_halted[%0d] obs=%b exp=%b", i, obs, V_ERR); end
    end
    do_reset();
    cyc(1, 0, 0, 0, 1, 0);
    expv = V_NORM;
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL tmo_cleared obs=%b exp=%b", obs, expv); end
  endtask

  task automatic test_halt();
    do_reset();
    // The halt cycle itself still gets the normal decode.
    cyc(1, 1, 0, 0, 1, 1);
    n_tests++;
    if (obs !== V_LU) begin n_fail++; $display("FAIL halt_cycle obs=%b exp=%b", obs, V_LU); end
    for (int i = 0; i < DRN; i++) begin
      cyc(1, 1'($urandom), 1'($urandom), 0, 1, 1'($urandom));
      n_tests++;
      if (obs !== V_DRN) begin n_fail++; $display("FAIL drain[%0d] obs=%b exp=%b", i, obs, V_DRN); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_tests++;
      if (obs !== V_HLT) begin n_fail++; $display("FAIL halted[%0d] obs=%b exp=%b", i, obs, V_HLT); end
    end
  endtask

  task automatic test_drain_stall();
    logic [10:0] seq [8];
    seq = '{V_DRN, V_DRN, V_FRZ, V_FRZ, V_DRN, V_DRN, V_HLT, V_HLT};
    do_reset();
    cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1'($urandom), (i == 2 || i == 3), !(i == 2 || i == 3), 0);
      n_tests++;
      if (obs !== seq[i]) begin n_fail++; $display("FAIL drain_stall[%0d] obs=%b exp=%b", i, obs, seq[i]); end
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 1);
    n_tests++;
    if (obs !== V_FRZ) begin n_fail++; $display("FAIL rst_drain_stall obs=%b exp=%b", obs, V_FRZ); end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== V_INIT) begin n_fail++; $display("FAIL rst_drain_init obs=%b exp=%b", obs, V_INIT); end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== V_NORM) begin n_fail++; $display("FAIL rst_drain_run obs=%b exp=%b", obs, V_NORM); end
  endtask

  task automatic test_random();
    int wait_run = 0;
    int e_st = 0, e_fl = 0, e_mw = 0;
    logic lu, br, req, rdy;
    logic [10:0] expv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lu  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      req = ($urandom_range(0, 2) != 0);
      rdy = (wait_run >= TMO - 1) ? 1'b1 : 1'($urandom);
      cyc(1, lu, br, req, rdy, 0);
      expv = ref_run(lu, br, req, rdy);
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL rand[%0d] obs=%b exp=%b", i, obs, expv); end
      if (req && !rdy) begin wait_run++; e_mw++; end
      else begin
        wait_run = 0;
        if (br) e_fl++;
        else if (lu) e_st++;
      end
    end
    cyc(1, 0, 0, 0, 1, 0);
    n_tests++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== {CNT_W'(PERF ? e_st : 0), CNT_W'(PERF ? e_fl : 0), CNT_W'(PERF ? e_mw : 0)}) begin
      n_fail++;
      $display("FAIL rand_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d", stall_cnt, flush_cnt, memwait_cnt,
               PERF ? e_st : 0, PERF ? e_fl : 0, PERF ? e_mw : 0);
    end
  endtask

  initial begin
    reset = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0;
    test_reset();
    test_load_use();
    test_mem_branch();
    test_timeout();
    test_halt();
    test_drain_stall();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Pipeline sequencing controller for the five-stage LEGv8 core. Drives the enable and synchronous-clear (flush) inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB `flopr`-based pipeline registers. It resolves memory wait states, taken-branch squashes, load-use bubbles and a controlled halt/drain. It sits beside the hazard detection unit in the top-level datapath.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters.
- `MEM_TIMEOUT`, 15, max consecutive `dmem_ready`-low cycles tolerated (1..255).
- `DRAIN_CYCLES`, 4, cycles spent draining after halt before freezing (1..15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  reset is synchronous and active-low (`reset`=0 at a rising edge resets).
- `load_use`  in  1  ID instruction depends on the load currently in EX.
- `branch_taken`  in  1  branch resolved taken in MEM.
- `dmem_req`  in  1  MEM stage holds a load/store.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `halt_req`  in  1  request to stop fetching and drain.
- `en_pc`, `en_ifid`, `en_idex`, `en_exmem`, `en_memwb`  out  1 each  register load enables.
- `flush_ifid`, `flush_idex`, `flush_exmem`, `flush_memwb`  out  1 each  load zero (bubble) at the next edge; these take priority over the enable inside the register.
- `halted`  out  1  core frozen.
- `mem_err`  out  1  sticky memory timeout flag.
- `stall_cnt`, `flush_cnt`, `memwait_cnt`  out  `CNT_W` each  performance counters.

## Operation
- States: INIT, RUN, MEM_WAIT, DRAIN, HALTED. State and counters are registered; enables and flushes are a combinational decode of state plus inputs, so they act on the same edge.
- Reset (`reset`=0 at an edge): the next state is INIT, the timeout and drain counters clear, `mem_err`=0, and the perf counters clear.
- INIT: `en_pc`=0, other enables=1, all flushes=1, `halted`=0. Lasts exactly one cycle after reset release, then the state goes to RUN.
- RUN/MEM_WAIT decode, in priority order:
  1. `dmem_req`=1 and `dmem_ready`=0: all enables=0 and all flushes=0. Branch and load-use are ignored; they persist because the pipeline is frozen. The next state is MEM_WAIT and the timeout counter increments.
  2. `branch_taken`=1: all enables=1; `flush_ifid`, `flush_idex` and `flush_exmem` are 1. This squashes the three younger instructions. `load_use` is ignored.
  3. `load_use`=1: `en_pc`=0, `en_ifid`=0, `flush_idex`=1, and the other enables are 1. This inserts one bubble.
  4. Otherwise all enables=1 and all flushes=0.
- Any cycle without case 1 returns the state to RUN and clears the timeout counter.
- Timeout: if the timeout counter reaches `MEM_TIMEOUT` while still waiting, then at that edge `mem_err` goes to 1 and the state goes to HALTED.
- Halt: `halt_req`=1 in a cycle not in case 1 moves the state to DRAIN at the next edge. In the same cycle the normal decode still applies.
- DRAIN: `en_pc`=0, `flush_ifid`=1, other enables=1, and the drain counter counts up. After `DRAIN_CYCLES` cycles the state goes to HALTED.
- A memory stall in DRAIN freezes the pipeline as in case 1, and the drain count pauses.
- A branch in DRAIN is ignored; the squash is unnecessary because fetch is stopped.
- HALTED: all enables=0, all flushes=0, `halted`=1. HALTED is exited only by reset.
- `halt_req` is ignored outside RUN/MEM_WAIT.

## Timing
- Decode-to-register latency is 0 cycles; stall and flush responses take effect at the edge that ends the cycle in which the input is seen.
- A load-use stall costs exactly 1 cycle.
- A taken branch costs 3 bubbles.
- A memory stall costs N cycles, where N is the number of cycles with `dmem_ready` low.
- `halted` rises `DRAIN_CYCLES`+1 edges after `halt_req` is sampled, provided there are no memory stalls.
- Reset mid-stall or mid-drain is honoured at the next edge regardless of inputs.
- Inputs must be stable before the rising edge; there are no combinational loops from outputs to inputs.

## Configuration
- `PIPE_PERF_COUNTERS_EN` defined: counters are live and saturate at all-ones.
  - `stall_cnt` increments on each load-use cycle.
  - `flush_cnt` increments on each branch-flush cycle.
  - `memwait_cnt` increments on each case-1 cycle.
- Not defined: counter registers are not built, the three ports are tied to 0, and the port list is unchanged.

## Test plan
- Reset held low for 3 cycles, then released:
  - while reset is low and for 1 cycle after release, `en_pc`=0 and flushes=1111;
  - on the next cycle all enables=1 and flushes=0000;
  - `mem_err`=0 and counters=0.
- `load_use`=1 for one cycle in RUN:
  - that cycle shows `en_pc`=0, `en_ifid`=0, `flush_idex`=1;
  - the next cycle is normal;
  - with counters enabled, `stall_cnt`=1.
- `dmem_req`=1, `dmem_ready`=0 for 3 cycles with `branch_taken`=1 throughout, then `dmem_ready`=1:
  - enables=0 for 3 cycles;
  - the fourth cycle shows flushes `flush_ifid`/`flush_idex`/`flush_exmem`=1;
  - `memwait_cnt`=3 and `flush_cnt`=1.
- `dmem_ready` held at 0 with `dmem_req`=1 for `MEM_TIMEOUT`=15 cycles: `mem_err`=1 and `halted`=1 after edge 15, and both hold until reset.
- `halt_req` pulse in RUN with `DRAIN_CYCLES`=4:
  - `en_pc`=0 and `flush_ifid`=1 for 4 cycles;
  - `halted`=1 at the 5th edge;
  - a later `load_use` or `branch_taken` has no effect.
- Reset asserted during DRAIN (cycle 2): the next cycle is INIT, then RUN with `halted`=0.
